spi_slave_shift: RTL and testbench

SPI_SLAVE_SHIFT -- requirements
Module: spi_slave_shift

---
 rtl/spi_slave_shift.sv | 115 +++++++++++
 tb/tb_spi_slave_shift.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_shift.sv
// spi_slave_shift: SPI slave shift engine with synchronized serial inputs and one-entry tx buffer
module spi_slave_shift #(
    parameter int MAX_CHAR = 32,
    parameter int LEN_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LEN_BITS-1:0] len,
    input  logic                lsb,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [MAX_CHAR-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [MAX_CHAR-1:0] rx_data,
    output logic                rx_valid,
    output logic                tip,
    output logic                tx_underrun,
    input  logic                ss_n,
    input  logic                sclk,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe
);
    localparam int CW = LEN_BITS + 1;

    logic [2:0]          ss_q, sc_q;
    logic [1:0]          mo_q, vld;
    logic                armed, full, mb;
    logic [MAX_CHAR-1:0] tx_buf, sr, rx_sr, load;
    logic [CW-1:0]       cnt, k, n;
    logic                rise, fall, lead, trail, samp, shft, done, ss_fall, ss_rise, start, fill;

    function automatic logic [CW-1:0] pos(input logic [CW-1:0] i);
        return lsb ? i : n - 1'b1 - i;
    endfunction

    function automatic logic pick(input logic [MAX_CHAR-1:0] d, input logic [CW-1:0] i);
        return 1'(d >> pos(i));
    endfunction

    assign n        = (len == '0) ? CW'(MAX_CHAR) : CW'(len) + 1'b1;
    assign rise     = sc_q[1] & ~sc_q[2];
    assign fall     = ~sc_q[1] & sc_q[2];
    assign lead     = cpol ? fall : rise;
    assign trail    = cpol ? rise : fall;
    assign samp     = tip && cnt != '0 && (cpha ? trail : lead);
    // a shift edge never runs ahead of the bits already sampled, so the
    // trailing edge that follows a character's last sample is ignored
    assign shft     = tip && (cpha ? lead : trail) && k <= n - cnt;
    assign done     = tip && cnt == '0;
    // armed only once ss_n has been seen high from the pin since reset
    assign ss_fall  = ~ss_q[1] & ss_q[2] & armed;
    assign ss_rise  = ss_q[1] & ~ss_q[2];
    assign start    = ss_fall | (done & ~ss_q[1]);
    assign fill     = tx_valid & ~full;
    assign load     = full ? tx_buf : '0;
    assign tx_ready = ~full;
    assign miso_oe  = ~ss_q[1];
    assign miso     = ~ss_q[1] & mb;

    // synchronizers, tx buffer, character sequencing and shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q        <= 3'b111;
            sc_q        <= '0;
            mo_q        <= '0;
            vld         <= '0;
            armed       <= 1'b0;
            full        <= 1'b0;
            tx_buf      <= '0;
            tip         <= 1'b0;
            cnt         <= '0;
            k           <= '0;
            mb          <= 1'b0;
            sr          <= '0;
            rx_sr       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            ss_q        <= {ss_q[1:0], ss_n};
            sc_q        <= {sc_q[1:0], sclk};
            mo_q        <= {mo_q[0], mosi};
            vld         <= {vld[0], 1'b1};
            armed       <= armed | (vld[1] & ss_q[1]);
            rx_valid    <= done;
            tx_underrun <= start & ~full;
            full        <= fill | (full & ~start);
            if (fill) tx_buf <= tx_data;
            if (done) rx_data <= rx_sr;
            if (start) begin
                tip   <= 1'b1;
                cnt   <= n;
                sr    <= load;
                rx_sr <= '0;
                mb    <= pick(load, '0);
                k     <= cpha ? '0 : CW'(1);
            end else if (done | (ss_rise & tip)) begin
                tip <= 1'b0;
                cnt <= '0;
                mb  <= 1'b0;
            end else begin
                if (samp) begin
                    cnt   <= cnt - 1'b1;
                    rx_sr <= rx_sr | (MAX_CHAR'(mo_q[1]) << pos(n - cnt));
                end
                if (shft) begin
                    mb <= pick(sr, k);
                    k  <= k + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_shift.sv
// tb_spi_slave_shift: scoreboard bench driving directed SPI frames into spi_slave_shift
module tb_spi_slave_shift;
    logic        clk = 0, rst = 1;
    logic [4:0]  len = 0;
    logic        lsb = 0, cpol = 0, cpha = 0;
    logic [31:0] tx_data = 0;
    logic        tx_valid = 0, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, tip, tx_underrun;
    logic        ss_n = 1, sclk = 0, mosi = 0;
    logic        miso, miso_oe;
    int          errors = 0, checks = 0, und = 0, u0;
    logic [31:0] exp_q[$];

    spi_slave_shift dut (
        .clk(clk), .rst(rst), .len(len), .lsb(lsb), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tip(tip), .tx_underrun(tx_underrun),
        .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops the expected word on every rx_valid and counts underrun pulses
    always @(negedge clk) begin
        if (tx_underrun) und++;
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h expected no rx_valid", rx_data);
            end else chk("rx_data", {32'h0, rx_data}, {32'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cfg(input logic cp, input logic ph, input logic [4:0] l, input logic ls);
        @(negedge clk);
        cpol = cp; cpha = ph; len = l; lsb = ls; sclk = cp;
        repeat (4) @(negedge clk);
    endtask

    task automatic push_tx(input logic [31:0] d);
        int t = 0;
        @(negedge clk);
        tx_data = d;
        tx_valid = 1;
        while (!tx_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("tx_ready_timeout", 0, 1);
        @(negedge clk);
        tx_valid = 0;
    endtask

    task automatic frame(input int n, input int nch, input logic [63:0] mo,
                         input logic [63:0] exp_miso, input int stop_at, input bit check_miso);
        logic [63:0] cap = 0;
        int b = 0, idx;
        @(negedge clk);
        ss_n = 0;
        repeat (8) @(negedge clk);
        for (int c = 0; c < nch; c++) begin
            for (int k = 0; k < n; k++) begin
                if (b == stop_at) return;
                idx = c * n + (lsb ? k : n - 1 - k);
                if (!cpha) begin
                    mosi = mo[idx];
                    repeat (4) @(negedge clk);
                    cap[idx] = miso;
                    sclk = ~cpol;
                    repeat (4) @(negedge clk);
                    sclk = cpol;
                end else begin
                    sclk = ~cpol;
                    mosi = mo[idx];
                    repeat (4) @(negedge clk);
                    cap[idx] = miso;
                    sclk = cpol;
                    if (b != n * nch - 1) repeat (4) @(negedge clk);
                end
                b++;
            end
        end
        @(negedge clk);
        ss_n = 1;
        repeat (6) @(negedge clk);
        if (check_miso) chk("miso_word", cap, exp_miso);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tip", tip, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_ready", tx_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 0;
        repeat (4) @(negedge clk);

        // mode 0, 8 bits MSB first
        cfg(0, 0, 7, 0);
        push_tx(32'hA5);
        chk("tx_ready_full", tx_ready, 0);
        exp_q.push_back(32'h3C);
        frame(8, 1, 64'h3C, 64'hA5, -1, 1);
        chk("m0_pending", exp_q.size(), 0);

        // mode 3, 16 bits LSB first
        cfg(1, 1, 15, 1);
        push_tx(32'h1234);
        u0 = und;
        exp_q.push_back(32'hBEEF);
        frame(16, 1, 64'hBEEF, 64'h1234, -1, 1);
        chk("m3_underrun", und - u0, 0);

        // len=0: two back-to-back 32-bit characters, second word loaded mid-frame
        cfg(1, 1, 0, 0);
        push_tx(32'hDEADBEEF);
        u0 = und;
        exp_q.push_back(32'h13579BDF);
        exp_q.push_back(32'hCAFEF00D);
        fork
            frame(32, 2, {32'hCAFEF00D, 32'h13579BDF}, {32'h01234567, 32'hDEADBEEF}, -1, 1);
            begin
                repeat (100) @(negedge clk);
                push_tx(32'h01234567);
            end
        join
        chk("b2b_underrun", und - u0, 0);
        repeat (20) @(negedge clk);
        chk("rx_hold", rx_data, 32'hCAFEF00D);

        // empty buffer at start
        cfg(0, 1, 7, 0);
        u0 = und;
        exp_q.push_back(32'h5A);
        frame(8, 1, 64'h5A, 64'h0, -1, 1);
        chk("empty_underrun", und - u0, 1);
        chk("empty_tx_ready", tx_ready, 1);

        // ss_n raised after 5 of 8 bits
        cfg(0, 0, 7, 0);
        push_tx(32'h77);
        frame(8, 1, 64'hC3, 64'h0, 5, 0);
        @(negedge clk);
        ss_n = 1;
        repeat (3) @(negedge clk);
        chk("abort_tip", tip, 0);
        chk("abort_miso_oe", miso_oe, 0);
        repeat (10) @(negedge clk);
        chk("abort_rx_hold", rx_data, 32'h5A);

        // reset mid-character, then a clean frame
        push_tx(32'h03);
        frame(8, 1, 64'hFF, 64'h0, 4, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 0;
        repeat (10) @(negedge clk);
        chk("post_rst_no_start", tip, 0);
        chk("post_rst_oe", miso_oe, 1);
        ss_n = 1;
        repeat (5) @(negedge clk);
        push_tx(32'hC3);
        exp_q.push_back(32'h96);
        frame(8, 1, 64'h96, 64'hC3, -1, 1);

        repeat (20) @(negedge clk);
        chk("rx_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
